// File: rtl/lt_pkg.sv
// Shared definitions for the LT degree generator.
// Holds the LFSR geometry (width, feedback taps, reset seed), the default
// degree width and the LFSR step function used by the top level.
package lt_pkg;

  localparam int unsigned LFSR_W        = 71;
  localparam int unsigned TAP_HI        = 70;
  localparam int unsigned TAP_LO        = 64;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 71'h1;
  localparam int unsigned DEG_W_DEFAULT = 9;

  typedef logic [LFSR_W-1:0]        lfsr_t;
  typedef logic [DEG_W_DEFAULT-1:0] deg_t;

  // Fibonacci step: shift left, feedback enters at bit 0.
  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/degree_cdf_rom.sv
// Degree CDF lookup table with a registered (1-cycle) synchronous read.
// Ports:
//   clk   - clock
//   addr  - table address (uniform random index)
//   data  - table entry for the address presented on the previous edge
// Contents are the identity table, entry[a] = a mod 2**DEG_W.
module degree_cdf_rom #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEG_W     = 9,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEG_W-1:0]  data
);

  // A non-empty image name is rejected at elaboration so that a build never
  // silently runs with a table other than the one it asked for.
  if (INIT_FILE != "") begin : g_init_file_check
    $error("degree_cdf_rom: INIT_FILE images are not supported by this table");
  end

  always_ff @(posedge clk) begin
    data <= DEG_W'(addr);
  end

endmodule

// File: rtl/lt_degree_gen.sv
// LT code degree generator: an LFSR indexes a degree CDF table, the entry is
// mapped (0 -> 1, optional clamp) and queued in a small FIFO that feeds a
// valid/ready consumer. Lookups are credit-limited so the FIFO never overflows,
// which keeps the degree sequence independent of the consumer's stall pattern.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   seed_load     - pulse: load seed (0 selects SEED_DEFAULT), flush pipeline
//   seed          - new LFSR state
//   cfg_max_deg   - degree clamp, 0 disables
//   deg_ready     - consumer accepts deg_random this cycle
//   deg_random    - degree at the FIFO head
//   deg_valid     - deg_random is valid
//   deg_count     - accepted degrees since reset / seed_load
module lt_degree_gen #(
  parameter int unsigned                DEG_W        = 9,
  parameter int unsigned                ADDR_W       = 10,
  parameter int unsigned                FIFO_DEPTH   = 4,
  parameter logic [lt_pkg::LFSR_W-1:0]  SEED_DEFAULT = lt_pkg::SEED_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [lt_pkg::LFSR_W-1:0] seed,
  input  logic [DEG_W-1:0]          cfg_max_deg,
  input  logic                      deg_ready,
  output logic [DEG_W-1:0]          deg_random,
  output logic                      deg_valid,
  output logic [31:0]               deg_count
);

  import lt_pkg::*;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lfsr_t              lfsr;
  logic [ADDR_W-1:0]  addr_q;
  logic               s1_v;
  logic               s2_v;
  logic [DEG_W-1:0]   rom_data;
  logic [DEG_W-1:0]   mapped;

  logic [DEG_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   occ;

  logic [CNT_W:0]     credit_used;
  logic               issue;
  logic               push;
  logic               pop;

  // Entries already in flight hold a FIFO slot, so a lookup is issued only
  // when every in-flight result is guaranteed room on arrival.
  assign credit_used = (CNT_W+1)'(occ) + (CNT_W+1)'(s1_v) + (CNT_W+1)'(s2_v);
  assign issue       = !seed_load && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign push        = s2_v && !seed_load;
  assign pop         = deg_valid && deg_ready && !seed_load;

  assign deg_valid  = (occ != '0);
  assign deg_random = mem[rd_ptr];

  degree_cdf_rom #(
    .ADDR_W (ADDR_W),
    .DEG_W  (DEG_W)
  ) u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (rom_data)
  );

  // Zero maps to degree 1 first; the clamp is never below 1 when enabled.
  always_comb begin
    mapped = (rom_data == '0) ? DEG_W'(1) : rom_data;
    if ((cfg_max_deg != '0) && (mapped > cfg_max_deg)) begin
      mapped = cfg_max_deg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= SEED_DEFAULT;
      addr_q <= '0;
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
    end else if (seed_load) begin
      lfsr <= (seed == '0) ? SEED_DEFAULT : seed;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= issue;
      s2_v <= s1_v;
      if (issue) begin
        addr_q <= lfsr[ADDR_W-1:0];
        lfsr   <= lfsr_next(lfsr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      deg_count <= '0;
    end else if (seed_load) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      deg_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= mapped;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        deg_count <= deg_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_lt_degree_gen.sv
module tb_lt_degree_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [70:0] seed;
  logic [8:0]  cfg_max_deg;
  logic        deg_ready;
  logic [8:0]  deg_random;
  logic        deg_valid;
  logic [31:0] deg_count;

  int errors = 0;
  int checks = 0;

  logic [70:0] m_lfsr;
  int          m_cfg;

  always #5 clk = ~clk;

  lt_degree_gen dut (
    .clk         (clk),
    .rst         (rst),
    .seed_load   (seed_load),
    .seed        (seed),
    .cfg_max_deg (cfg_max_deg),
    .deg_ready   (deg_ready),
    .deg_random  (deg_random),
    .deg_valid   (deg_valid),
    .deg_count   (deg_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference degree for an LFSR state: identity table, 0 -> 1, clamp.
  function automatic logic [31:0] ref_deg(input logic [70:0] s, input int cfg);
    int v;
    v = int'(s[9:0]) % 512;
    if (v == 0) v = 1;
    if (cfg != 0 && v > cfg) v = cfg;
    return 32'(v);
  endfunction

  task automatic m_next(output logic [31:0] d);
    d = ref_deg(m_lfsr, m_cfg);
    m_lfsr = {m_lfsr[69:0], m_lfsr[70] ^ m_lfsr[64]};
  endtask

  task automatic wait_first(input string tag);
    int lat;
    lat = 0;
    while (!deg_valid && lat < 8) begin
      tick;
      lat++;
    end
    chk(tag, 32'(lat), 32'd3);
  endtask

  task automatic restart(input logic [70:0] sv, input logic [70:0] model_seed);
    seed      = sv;
    seed_load = 1'b1;
    tick;
    seed_load = 1'b0;
    chk("seed_load_valid_clear", 32'(deg_valid), 32'd0);
    chk("seed_load_count_clear", deg_count, 32'd0);
    m_lfsr = model_seed;
    wait_first("seed_load_latency");
  endtask

  task automatic stream(input int n, input int base);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      m_next(e);
      chk("stream_valid", 32'(deg_valid), 32'd1);
      chk("stream_deg", 32'(deg_random), e);
      chk("stream_count", deg_count, 32'(base + i));
      tick;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    logic [31:0] hand [5];
    logic [8:0]  prev;
    logic        changed;
    logic        held;
    logic [8:0]  held_val;
    int          acc;
    int          cyc;
    int          seq_err;
    int          stab_err;

    hand[0] = 1; hand[1] = 2; hand[2] = 4; hand[3] = 8; hand[4] = 16;
    rst = 1'b1; seed_load = 1'b0; seed = '0; cfg_max_deg = '0; deg_ready = 1'b1;
    m_cfg = 0;

    // Reset state and first-output latency.
    @(negedge clk);
    tick;
    tick;
    chk("reset_valid", 32'(deg_valid), 32'd0);
    chk("reset_deg", 32'(deg_random), 32'd0);
    chk("reset_count", deg_count, 32'd0);
    rst = 1'b0;
    wait_first("reset_latency");
    for (int i = 0; i < 5; i++) begin
      chk("reset_seq_hand", 32'(deg_random), hand[i]);
      chk("reset_seq_count", deg_count, 32'(i));
      tick;
    end
    m_lfsr = 71'h20;
    stream(70, 5);

    // seed 0x400: table entry 0 maps to degree 1.
    restart(71'h400, 71'h400);
    chk("seed400_first", 32'(deg_random), 32'd1);
    stream(4, 0);

    // seed 0 behaves like reset.
    restart(71'h0, 71'h1);
    chk("seed0_first", 32'(deg_random), 32'd1);
    stream(8, 0);

    // Clamp enabled vs disabled with seed 7.
    cfg_max_deg = 9'd4; m_cfg = 4;
    restart(71'h7, 71'h7);
    chk("clamp4_first", 32'(deg_random), 32'd4);
    tick;
    chk("clamp4_second", 32'(deg_random), 32'd4);
    cfg_max_deg = 9'd0; m_cfg = 0;
    restart(71'h7, 71'h7);
    chk("noclamp_first", 32'(deg_random), 32'd7);
    tick;
    chk("noclamp_second", 32'(deg_random), 32'd14);
    tick;
    chk("noclamp_third", 32'(deg_random), 32'd28);

    // Long stall: FIFO fills, head holds, then drains in order with no gap.
    deg_ready = 1'b0;
    restart(71'h1, 71'h1);
    prev = deg_random;
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (deg_random !== prev || deg_valid !== 1'b1) changed = 1'b1;
    end
    chk("stall_head_stable", 32'(changed), 32'd0);
    chk("stall_head_value", 32'(deg_random), 32'd1);
    chk("stall_count", deg_count, 32'd0);
    deg_ready = 1'b1;
    stream(12, 0);

    // Random 30% ready: accepted sequence must match the ready=1 sequence.
    restart(71'h1, 71'h1);
    acc = 0; cyc = 0; seq_err = 0; stab_err = 0; held = 1'b0; held_val = '0;
    while (acc < 1000 && cyc < 20000) begin
      if (held && (deg_valid !== 1'b1 || deg_random !== held_val)) stab_err++;
      deg_ready = ($urandom_range(0, 99) < 30);
      if (deg_valid && deg_ready) begin
        m_next(e);
        if (32'(deg_random) !== e) seq_err++;
        acc++;
      end
      held = deg_valid && !deg_ready;
      held_val = deg_random;
      tick;
      cyc++;
    end
    chk("rand_accepts", 32'(acc), 32'd1000);
    chk("rand_seq_errors", 32'(seq_err), 32'd0);
    chk("rand_stall_errors", 32'(stab_err), 32'd0);
    chk("rand_count", deg_count, 32'd1000);

    // seed_load with FIFO full.
    deg_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    chk("full_valid", 32'(deg_valid), 32'd1);
    chk("full_count_held", deg_count, 32'd1000);
    seed = 71'h7;
    seed_load = 1'b1;
    tick;
    seed_load = 1'b0;
    chk("flush_seed_valid", 32'(deg_valid), 32'd0);
    chk("flush_seed_count", deg_count, 32'd0);

    // rst together with seed_load while full: reset wins.
    for (int i = 0; i < 8; i++) tick;
    chk("refill_valid", 32'(deg_valid), 32'd1);
    rst = 1'b1;
    seed_load = 1'b1;
    seed = 71'h7;
    tick;
    rst = 1'b0;
    seed_load = 1'b0;
    chk("rst_full_valid", 32'(deg_valid), 32'd0);
    chk("rst_full_count", deg_count, 32'd0);
    chk("rst_full_deg", 32'(deg_random), 32'd0);
    deg_ready = 1'b1;
    m_lfsr = 71'h1;
    wait_first("rst_full_latency");
    stream(8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lt_degree_gen.md
LT_DEGREE_GEN -- requirements
Module: lt_degree_gen

Interface
REQ-001 Parameter DEG_W, default 9: width of the degree output.
REQ-002 Parameter ADDR_W, default 10: CDF table address width; table holds 2**ADDR_W entries of DEG_W bits.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth; power of two, >= 4.
REQ-004 Parameter SEED_DEFAULT, default 71'h1: LFSR reset seed; nonzero.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 seed_load  input  1  one-cycle pulse: load seed, flush pipeline.
REQ-008 seed  input  71  new LFSR state, sampled when seed_load=1.
REQ-009 cfg_max_deg  input  DEG_W  degree clamp; 0 disables clamping.
REQ-010 deg_ready  input  1  consumer accepts deg_random this cycle.
REQ-011 deg_random  output  DEG_W  degree value, registered.
REQ-012 deg_valid  output  1  deg_random holds a valid degree.
REQ-013 deg_count  output  32  number of degrees accepted (valid&&ready) since reset or seed_load, wraps at 2**32.

Function
REQ-014 LFSR: 71-bit Fibonacci, shift left; new bit0 = bit70 XOR bit64; advances only on a lookup issue.
REQ-015 Lookup issue: address = LFSR[ADDR_W-1:0] of the state before advance; issue when inflight + fifo_occupancy < FIFO_DEPTH and seed_load=0.
REQ-016 Pipeline: issue edge k registers address; table output valid after edge k+1; result written to FIFO on edge k+2.
REQ-017 First deg_valid after reset asserts on the 3rd rising edge after rst deasserts; with deg_ready held high, throughput is one degree per cycle thereafter.
REQ-018 Mapping: table value 0 maps to degree 1; if cfg_max_deg != 0 and value > cfg_max_deg, output cfg_max_deg; applied before the FIFO write.
REQ-019 Handshake: pop on deg_valid && deg_ready; deg_random stable while deg_valid=1 and deg_ready=0; deg_valid never drops without a pop.
REQ-020 FIFO: no overflow by construction (credit rule REQ-015); simultaneous push and pop at full or empty keeps occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 seed_load: takes precedence over issue and pop; next cycle LFSR = seed (SEED_DEFAULT if seed == 0), FIFO and in-flight entries discarded, deg_valid=0, deg_count=0.
REQ-022 Degree sequence depends only on seed and table contents, never on deg_ready stall pattern.
REQ-023 cfg_max_deg sampled at mapping time; changes affect only entries not yet written to the FIFO.

Reset
REQ-024 While rst=1 on an edge: LFSR = SEED_DEFAULT, FIFO empty, in-flight cleared, deg_valid=0, deg_random=0, deg_count=0.
REQ-025 Reset mid-operation discards all buffered degrees; rst has priority over seed_load.

Structure
REQ-026 Shared package lt_pkg holds LFSR_W=71, tap positions (70, 64), SEED_DEFAULT and the degree/width typedefs.
REQ-027 One sub-module degree_cdf_rom (parameters ADDR_W, DEG_W, init file) with a synchronous 1-cycle registered read; everything else inline.

Verification (identity table: entry[a] = a mod 2**DEG_W, DEG_W=9, ADDR_W=10)
REQ-028 Reset release, deg_ready=1 -> deg_valid rises on edge 3; degrees 1, 2, 4, 8, 16 ... (seed 1 shifting); deg_count increments each cycle.
REQ-029 seed_load with seed=71'h400 -> first degree 1 (table 0 mapped to 1); seed=0 -> sequence identical to reset.
REQ-030 cfg_max_deg=4, seed=71'h7 -> first degree 4; cfg_max_deg=0 -> 7.
REQ-031 deg_ready random 30% duty over 1000 accepts -> accepted sequence identical to the ready=1 run; deg_random stable during stalls; no loss or duplication.
REQ-032 deg_ready=0 for 20 cycles -> occupancy saturates at FIFO_DEPTH, LFSR frozen; then ready=1 -> FIFO_DEPTH buffered values drain in order, then one per cycle.
REQ-033 seed_load and rst asserted with FIFO full -> next cycle deg_valid=0, deg_count=0; post-reset sequence restarts per REQ-028.
